// File: rtl/branch_resolver.sv
// Branch resolver: carries fetched branch/jump info through IF/ID -> ID/EX -> EX/MEM
// and redirects fetch from EX/MEM. Optional macro JUMP_EN enables unconditional j decode.
module branch_resolver #(
  parameter int         WIDTH  = 32,
  parameter logic [5:0] BEQ_OP = 6'h04,
  parameter logic [5:0] BNE_OP = 6'h05
`ifdef JUMP_EN
  ,
  parameter logic [5:0] J_OP   = 6'h02
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pc_next_in,
  input  logic [31:0]      instr_in,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic [4:0]       rs_addr,
  output logic [4:0]       rt_addr,
  output logic [WIDTH-1:0] pc_branch,
  output logic             pc_source,
  output logic             flush
);

  logic             ifid_valid_q, ifid_valid_d;
  logic [WIDTH-1:0] ifid_pc_q, ifid_pc_d;
  logic [31:0]      ifid_instr_q, ifid_instr_d;

  logic             idex_valid_q, idex_valid_d;
  logic             idex_is_beq_q, idex_is_beq_d;
  logic             idex_is_bne_q, idex_is_bne_d;
  logic             idex_eq_q, idex_eq_d;
  logic [WIDTH-1:0] idex_target_q, idex_target_d;
`ifdef JUMP_EN
  logic             idex_is_j_q, idex_is_j_d;
`endif

  logic             exmem_taken_q, exmem_taken_d;
  logic [WIDTH-1:0] pc_branch_q, pc_branch_d;

  logic [5:0]       opcode;
  logic [15:0]      imm;
  logic [WIDTH-1:0] br_offset;
  logic             taken_cond;

  assign rs_addr   = ifid_instr_q[25:21];
  assign rt_addr   = ifid_instr_q[20:16];
  assign pc_branch = pc_branch_q;
  assign pc_source = exmem_taken_q;
  assign flush     = exmem_taken_q;

  always_comb begin
    // A redirect in flight kills everything younger, including what is captured this edge.
    ifid_valid_d = ~exmem_taken_q;
    ifid_pc_d    = pc_next_in;
    ifid_instr_d = instr_in;

    opcode        = ifid_instr_q[31:26];
    imm           = ifid_instr_q[15:0];
    br_offset     = {{(WIDTH-18){imm[15]}}, imm, 2'b00};
    idex_is_beq_d = (opcode == BEQ_OP);
    idex_is_bne_d = (opcode == BNE_OP);
    idex_eq_d     = (rs_data == rt_data);
    idex_valid_d  = ifid_valid_q & ~exmem_taken_q;
    idex_target_d = ifid_pc_q + br_offset;
`ifdef JUMP_EN
    idex_is_j_d   = (opcode == J_OP);
    if (idex_is_j_d) begin
      idex_target_d = {ifid_pc_q[WIDTH-1:WIDTH-4], ifid_instr_q[25:0], 2'b00};
    end
`endif

    taken_cond = (idex_is_beq_q & idex_eq_q) | (idex_is_bne_q & ~idex_eq_q);
`ifdef JUMP_EN
    taken_cond = taken_cond | idex_is_j_q;
`endif
    exmem_taken_d = idex_valid_q & ~exmem_taken_q & taken_cond;
    pc_branch_d   = exmem_taken_d ? idex_target_q : pc_branch_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ifid_valid_q  <= 1'b0;
      ifid_pc_q     <= '0;
      ifid_instr_q  <= '0;
      idex_valid_q  <= 1'b0;
      idex_is_beq_q <= 1'b0;
      idex_is_bne_q <= 1'b0;
      idex_eq_q     <= 1'b0;
      idex_target_q <= '0;
`ifdef JUMP_EN
      idex_is_j_q   <= 1'b0;
`endif
      exmem_taken_q <= 1'b0;
      pc_branch_q   <= '0;
    end else begin
      ifid_valid_q  <= ifid_valid_d;
      ifid_pc_q     <= ifid_pc_d;
      ifid_instr_q  <= ifid_instr_d;
      idex_valid_q  <= idex_valid_d;
      idex_is_beq_q <= idex_is_beq_d;
      idex_is_bne_q <= idex_is_bne_d;
      idex_eq_q     <= idex_eq_d;
      idex_target_q <= idex_target_d;
`ifdef JUMP_EN
      idex_is_j_q   <= idex_is_j_d;
`endif
      exmem_taken_q <= exmem_taken_d;
      pc_branch_q   <= pc_branch_d;
    end
  end

`ifndef SYNTHESIS
  // The redirect is a single-cycle pulse; the flush must always suppress a follow-on branch.
  pulse_single_cycle: assert property (@(posedge clk) disable iff (reset) pc_source |=> !pc_source);
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Scoreboard bench for branch_resolver: stimulus pushes expected redirects,
// a negedge monitor pops and compares pc_source/flush/pc_branch every cycle.
module tb_branch_resolver;

  localparam logic [5:0] BEQ = 6'h04;
  localparam logic [5:0] BNE = 6'h05;
  localparam logic [5:0] JMP = 6'h02;
  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef struct {
    int          cyc;
    logic [31:0] target;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc_next_in = '0;
  logic [31:0] instr_in = '0;
  logic [31:0] rs_data, rt_data;
  logic [4:0]  rs_addr, rt_addr;
  logic [31:0] pc_branch;
  logic        pc_source, flush;

  logic [31:0] regfile [32];
  exp_t        sb [$];
  logic [31:0] last_target = '0;
  int          cyc = 0;
  int          check_count = 0;
  int          pass_count = 0;

  assign rs_data = regfile[rs_addr];
  assign rt_data = regfile[rt_addr];

  branch_resolver dut (
    .clk        (clk),
    .reset      (reset),
    .pc_next_in (pc_next_in),
    .instr_in   (instr_in),
    .rs_data    (rs_data),
    .rt_data    (rt_data),
    .rs_addr    (rs_addr),
    .rt_addr    (rt_addr),
    .pc_branch  (pc_branch),
    .pc_source  (pc_source),
    .flush      (flush)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual !== expected)
      $display("[TB] FAIL %s at cycle %0d: got %h expected %h", name, cyc, actual, expected);
    else
      pass_count++;
  endtask

  task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] instr,
                               input bit taken, input logic [31:0] target);
    exp_t e;
    @(negedge clk);
    pc_next_in = pc;
    instr_in   = instr;
    if (taken) begin
      e.cyc    = cyc + 3;
      e.target = target;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(32'h0, NOP, 1'b0, 32'h0);
  endtask

  // Monitor: one expected-vs-actual evaluation per cycle, decoupled from stimulus.
  always @(negedge clk) begin
    bit exp_pulse;
    if (!reset) begin
      exp_pulse = (sb.size() > 0) && (sb[0].cyc == cyc);
      if (exp_pulse) last_target = sb[0].target;
      checkOutput("pc_source", {31'b0, pc_source}, {31'b0, exp_pulse});
      checkOutput("flush", {31'b0, flush}, {31'b0, exp_pulse});
      checkOutput("pc_branch", pc_branch, last_target);
      if (exp_pulse) void'(sb.pop_front());
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) regfile[i] = '0;
    regfile[1] = 32'd5;
    regfile[2] = 32'd5;
    regfile[3] = 32'd7;
    regfile[4] = 32'd7;
    regfile[5] = 32'd8;

    #2;
    checkOutput("reset_pc_source", {31'b0, pc_source}, 32'h0);
    checkOutput("reset_flush", {31'b0, flush}, 32'h0);
    checkOutput("reset_pc_branch", pc_branch, 32'h0);
    #10 reset = 1'b0;

    $display("[TB] beq taken, 0x14 + imm 3");
    applyStimulus(32'h14, mk(BEQ, 5'd1, 5'd2, 16'h0003), 1'b1, 32'h20);
    idle(5);

    $display("[TB] reset while a taken beq sits in ID/EX");
    applyStimulus(32'h40, mk(BEQ, 5'd1, 5'd2, 16'h0010), 1'b0, 32'h0);
    idle(2);
    #3 reset = 1'b1;
    sb.delete();
    last_target = '0;
    #1;
    checkOutput("midreset_pc_source", {31'b0, pc_source}, 32'h0);
    checkOutput("midreset_flush", {31'b0, flush}, 32'h0);
    checkOutput("midreset_pc_branch", pc_branch, 32'h0);
    @(negedge clk);
    #3 reset = 1'b0;
    idle(6);

    $display("[TB] negative offset and bne cases");
    applyStimulus(32'h14, mk(BEQ, 5'd1, 5'd2, 16'hFFFE), 1'b1, 32'h0C);
    idle(5);
    applyStimulus(32'h14, mk(BNE, 5'd3, 5'd4, 16'h0003), 1'b0, 32'h0);
    idle(5);
    applyStimulus(32'h14, mk(BNE, 5'd3, 5'd5, 16'h0003), 1'b1, 32'h20);
    idle(5);
    applyStimulus(32'hFFFF_FFFC, mk(BEQ, 5'd1, 5'd2, 16'h0001), 1'b1, 32'h0);
    idle(5);
    applyStimulus(32'h100, mk(BEQ, 5'd1, 5'd5, 16'h0004), 1'b0, 32'h0);
    applyStimulus(32'h104, mk(6'h00, 5'd1, 5'd2, 16'h0004), 1'b0, 32'h0);
    applyStimulus(32'h108, mk(6'h23, 5'd1, 5'd2, 16'h0004), 1'b0, 32'h0);
    idle(5);

    $display("[TB] back-to-back taken branches");
    applyStimulus(32'h14, mk(BEQ, 5'd1, 5'd2, 16'h0003), 1'b1, 32'h20);
    applyStimulus(32'h18, mk(BEQ, 5'd1, 5'd2, 16'h0005), 1'b0, 32'h0);
    idle(5);

    $display("[TB] branch captured in the flush cycle, then first right-path branch");
    applyStimulus(32'h200, mk(BNE, 5'd1, 5'd5, 16'h0001), 1'b1, 32'h204);
    idle(2);
    applyStimulus(32'h300, mk(BEQ, 5'd1, 5'd2, 16'h0001), 1'b0, 32'h0);
    applyStimulus(32'h400, mk(BEQ, 5'd3, 5'd4, 16'h0002), 1'b1, 32'h408);
    idle(5);

    $display("[TB] jump");
`ifdef JUMP_EN
    applyStimulus(32'h1000_0004, {JMP, 26'h000_0040}, 1'b1, 32'h1000_0100);
`else
    applyStimulus(32'h1000_0004, {JMP, 26'h000_0040}, 1'b0, 32'h0);
`endif
    idle(6);

    checkOutput("scoreboard_drain", sb.size(), 32'h0);
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
